mdsa_host_seq: RTL and testbench

MDSA_HOST_SEQ -- requirements
Module: mdsa_host_seq

---
 rtl/mdsa_host_seq.sv | 158 +++++++++++++++
 tb/tb_mdsa_host_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdsa_host_seq.sv
// Host-side sequencer for the matrix sort accelerator: buffers one frame of N
// elements, hands it to the sort controller, supervises the run and streams the sorted frame out.
module mdsa_host_seq #(
  parameter int DW      = 8,
  parameter int N       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic            start,
  output logic            fsm_en,
  input  logic            fsm_ready,
  input  logic            fsm_oe,
  output logic [N*DW-1:0] load_data,
  input  logic [N*DW-1:0] sorted_data,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic            busy,
  output logic            err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [7:0]    TMO_MAX  = 8'(TIMEOUT);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    tmo_cnt_q, tmo_cnt_d;
  logic          start_q, start_d;
  logic          err_q, err_d;
  // Keeps in_ready low until the first clock edge after reset release.
  logic          live_q;

  logic [DW-1:0] ibuf_q [N];
  logic [DW-1:0] obuf_q [N];

  logic in_acc;
  logic oe_cap;
  logic tmo_hit;

  assign in_acc  = live_q && (state_q == S_LOAD) && in_valid;
  assign oe_cap  = (state_q == S_RUN) && fsm_oe;
  assign tmo_hit = ((tmo_cnt_q + 8'd1) == TMO_MAX);

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    tmo_cnt_d = tmo_cnt_q;
    start_d   = 1'b0;
    err_d     = err_q;
    case (state_q)
      S_LOAD: begin
        if (in_acc) begin
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            state_d  = S_ARM;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      S_ARM: begin
        if (fsm_ready) begin
          start_d   = 1'b1;
          tmo_cnt_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
        // A result arriving on the timeout cycle is still taken.
        if (fsm_oe) begin
          rd_idx_d = '0;
          state_d  = S_DRAIN;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            state_d  = S_LOAD;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_LOAD;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      tmo_cnt_q <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      tmo_cnt_q <= tmo_cnt_d;
      start_q   <= start_d;
      err_q     <= err_d;
      live_q    <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_buf
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ibuf_q[gi] <= '0;
        end else if (in_acc && (wr_idx_q == IW'(gi))) begin
          ibuf_q[gi] <= in_data;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          obuf_q[gi] <= '0;
        end else if (oe_cap) begin
          obuf_q[gi] <= sorted_data[gi*DW +: DW];
        end
      end

      assign load_data[gi*DW +: DW] = ibuf_q[gi];
    end
  endgenerate

  assign in_ready  = live_q && (state_q == S_LOAD);
  assign start     = start_q;
  assign fsm_en    = (state_q == S_ARM) || (state_q == S_RUN);
  assign out_valid = (state_q == S_DRAIN);
  assign out_data  = obuf_q[rd_idx_q];
  assign out_last  = (state_q == S_DRAIN) && (rd_idx_q == LAST_IDX);
  assign busy      = (state_q != S_LOAD);
  assign err       = err_q;

endmodule

// File: tb/tb_mdsa_host_seq.sv
// Scoreboard bench for mdsa_host_seq: the bench plays both the upstream source
// and the sort controller, and checks the drained stream against what it sent.
module tb_mdsa_host_seq;
  localparam int DW = 8;
  localparam int N  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic            start;
  logic            fsm_en;
  logic            fsm_ready;
  logic            fsm_oe;
  logic [N*DW-1:0] load_data;
  logic [N*DW-1:0] sorted_data;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;
  logic            busy;
  logic            err;

  always #5 clk = ~clk;

  mdsa_host_seq #(.DW(DW), .N(N), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .fsm_en(fsm_en), .fsm_ready(fsm_ready), .fsm_oe(fsm_oe),
    .load_data(load_data), .sorted_data(sorted_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] frame  [N];
  logic [DW-1:0] sorted [N];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples at the falling edge, where bench inputs and DUT outputs are settled.
  task automatic monitor();
    logic          pv;
    logic [DW-1:0] pd;
    logic          pl;
    exp_t          e;
    pv = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (pv && out_valid) begin
        chk("stall_data", out_data, pd);
        chk("stall_last", out_last, pl);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", out_last, e.last);
        end
      end
      pv = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
    end
  endtask

  task automatic load_frame(input int count);
    for (int i = 0; i < count; i++) begin
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = frame[i];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_load_data();
    for (int i = 0; i < N; i++)
      chk("load_data", load_data[i*DW +: DW], frame[i]);
  endtask

  task automatic drain_wait(input bit toggle, output int nv);
    bit done;
    done = 1'b0;
    nv   = 0;
    for (int c = 0; c < 200; c++) begin
      if (sb.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
      if (out_valid) nv++;
      if (toggle) out_ready = ~out_ready;
      step();
    end
    chk("drain_timeout", done, 1);
    out_ready = 1'b1;
  endtask

  task automatic issue_oe(input bit toggle);
    exp_t e;
    int   nv;
    for (int i = 0; i < N; i++) begin
      sorted_data[i*DW +: DW] = sorted[i];
      e.data = sorted[i];
      e.last = (i == N - 1);
      sb.push_back(e);
    end
    fsm_oe = 1'b1;
    step();
    fsm_oe = 1'b0;
    chk("oe_to_valid", out_valid, 1);
    drain_wait(toggle, nv);
    if (!toggle) chk("drain_cycles", nv, N);
  endtask

  initial begin
    int ns;
    int base;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; fsm_ready = 1'b0; fsm_oe = 1'b0;
    sorted_data = '0; out_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_fsm_en", fsm_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err, 0);
    chk("rst_load_data", load_data, 0);
    rst = 1'b1;
    #1;
    chk("release_in_ready_pre", in_ready, 0);
    step();
    chk("release_in_ready", in_ready, 1);

    // Back-to-back load of 15..0 with the controller ready
    for (int i = 0; i < N; i++) frame[i] = DW'(N - 1 - i);
    fsm_ready = 1'b1;
    load_frame(N);
    chk("arm_start_early", start, 0);
    chk("arm_fsm_en", fsm_en, 1);
    chk("arm_in_ready", in_ready, 0);
    chk("arm_busy", busy, 1);
    step();
    chk("start_pulse", start, 1);
    check_load_data();
    step();
    chk("start_width", start, 0);

    // Sorted result 0..15 with a free-running sink
    for (int i = 0; i < N; i++) sorted[i] = DW'(i);
    issue_oe(1'b0);
    chk("post_drain_in_ready", in_ready, 1);

    // Stalled sink, toggling every cycle
    base = $urandom_range(0, 255);
    for (int i = 0; i < N; i++) frame[i] = DW'($urandom_range(0, 255));
    load_frame(N);
    step();
    chk("start_pulse2", start, 1);
    for (int i = 0; i < N; i++) sorted[i] = DW'(base + 7 * i);
    issue_oe(1'b1);
    chk("post_toggle_in_ready", in_ready, 1);

    // Controller not ready for 50 cycles
    fsm_ready = 1'b0;
    for (int i = 0; i < N; i++) frame[i] = DW'($urandom_range(0, 255));
    load_frame(N);
    ns = 0;
    repeat (50) begin
      step();
      if (start) ns++;
    end
    chk("start_while_not_ready", ns, 0);
    chk("hold_fsm_en", fsm_en, 1);
    fsm_ready = 1'b1;
    chk("start_before_ready_edge", start, 0);
    step();
    chk("start_after_ready", start, 1);
    for (int i = 0; i < N; i++) sorted[i] = DW'($urandom_range(0, 255));
    issue_oe(1'b0);

    // Timeout without fsm_oe
    for (int i = 0; i < N; i++) frame[i] = DW'(i * 3);
    load_frame(N);
    step();
    chk("start_tmo", start, 1);
    repeat (254) step();
    chk("tmo_err_before", err, 0);
    chk("tmo_fsm_en_before", fsm_en, 1);
    step();
    chk("tmo_err", err, 1);
    chk("tmo_in_ready", in_ready, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_out_valid", out_valid, 0);
    repeat (3) step();
    chk("tmo_err_sticky", err, 1);
    chk("tmo_no_output", sb.size(), 0);

    // Reset clears err, then fsm_oe exactly on the timeout cycle
    rst = 1'b0;
    step();
    chk("rst_clears_err", err, 0);
    rst = 1'b1;
    step();
    load_frame(N);
    step();
    chk("start_tmo2", start, 1);
    repeat (254) step();
    for (int i = 0; i < N; i++) sorted[i] = DW'(255 - i);
    issue_oe(1'b0);
    chk("oe_on_tmo_err", err, 0);

    // Reset arriving with the 7th element of a frame
    fsm_ready = 1'b0;
    for (int i = 0; i < N; i++) frame[i] = DW'(8'hA0 + i);
    load_frame(6);
    in_valid = 1'b1;
    in_data  = frame[6];
    rst      = 1'b0;
    step();
    in_valid = 1'b0;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_load_data", load_data, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b1;
    step();
    for (int i = 0; i < N; i++) frame[i] = DW'($urandom_range(0, 255));
    load_frame(N - 1);
    step();
    step();
    chk("partial_fsm_en", fsm_en, 0);
    chk("partial_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = frame[N-1];
    step();
    in_valid = 1'b0;
    chk("full_fsm_en", fsm_en, 1);
    check_load_data();
    fsm_ready = 1'b1;
    step();
    chk("midrst_start", start, 1);
    for (int i = 0; i < N; i++) sorted[i] = DW'($urandom_range(0, 255));
    issue_oe(1'b0);
    chk("final_in_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
